// File: rtl/weakcore_mem.sv
// Single-port word RAM responding on the weakcore bus with configurable wait states and byte-masked writes.
// Optional sticky out-of-range error capture is enabled with `define WEAKCORE_MEM_ERR_EN.
module weakcore_mem #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic [31:0] bus_addr,
  input  logic        bus_wr,
  input  logic [3:0]  bus_wr_mask,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack
`ifdef WEAKCORE_MEM_ERR_EN
  ,
  output logic        bus_err,
  output logic [31:0] err_addr
`endif
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);
  localparam logic [32:0] LO33   = {1'b0, ADDR_BASE};
  localparam logic [32:0] HI33   = LO33 + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        wr_q;
  logic [3:0]  mask_q;

  logic        capture, enter_ack;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_wr;
  logic [3:0]  acc_mask;
  logic [32:0] a33, off33;
  logic        in_range;
  logic [AW-1:0] idx;
  logic        unused_off;

  logic [31:0] mem [DEPTH_WORDS];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus_req) state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
      S_WAIT: if (cnt_q == 4'd1) state_d = S_ACK;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs; with zero wait states the access happens on the capture
  // edge itself, so the live bus fields are used instead of the latched copy.
  always_comb begin
    capture   = (state_q == S_IDLE) && bus_req;
    enter_ack = (state_q != S_ACK) && (state_d == S_ACK);
    cnt_d     = cnt_q;
    if (capture)                 cnt_d = WAIT_N;
    else if (state_q == S_WAIT)  cnt_d = cnt_q - 4'd1;
    if (state_q == S_IDLE) begin
      acc_addr  = bus_addr;
      acc_wr    = bus_wr;
      acc_mask  = bus_wr_mask;
      acc_wdata = bus_wdata;
    end else begin
      acc_addr  = addr_q;
      acc_wr    = wr_q;
      acc_mask  = mask_q;
      acc_wdata = wdata_q;
    end
  end

  // 33-bit decode so ADDR_BASE + size cannot wrap
  assign a33        = {1'b0, acc_addr};
  assign off33      = a33 - LO33;
  assign in_range   = (a33 >= LO33) && (a33 < HI33);
  assign idx        = off33[AW+1:2];
  assign unused_off = ^{off33[32:AW+2], off33[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wr_q    <= 1'b0;
      mask_q  <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      cnt_q <= cnt_d;
      if (capture) begin
        addr_q  <= bus_addr;
        wr_q    <= bus_wr;
        mask_q  <= bus_wr_mask;
        wdata_q <= bus_wdata;
      end
      rdata_q <= (enter_ack && !acc_wr && in_range) ? mem[idx] : 32'h0;
    end
  end

  // Array has no reset; the rst term drops a write whose edge meets reset.
  always_ff @(posedge clk) begin
    if (enter_ack && acc_wr && in_range && rst) begin
      for (int i = 0; i < 4; i++)
        if (acc_mask[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
    end
  end

  assign bus_ack   = (state_q == S_ACK);
  assign bus_rdata = rdata_q;

`ifdef WEAKCORE_MEM_ERR_EN
  logic        err_q;
  logic [31:0] err_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else if (enter_ack && !in_range && !err_q) begin
      err_q      <= 1'b1;
      err_addr_q <= acc_addr;
    end
  end

  assign bus_err  = err_q;
  assign err_addr = err_addr_q;
`endif

endmodule

// File: doc/weakcore_mem.md
Name: weakcore_mem

Overview:
- Single-port synchronous RAM that acts as the responder on the weakcore bus: it services instruction fetches and load/store accesses issued by the core.
- It accepts one request at a time, inserts a configurable number of wait states, performs byte-masked writes, and returns read data together with a single-cycle acknowledge.
- It sits directly on the core's bus_* signals in the top-level SoC.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 4096, number of 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 0, extra cycles between request capture and ack; 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- bus_req  input  1  request; held high by the initiator until ack.
- bus_addr  input  32  byte address; bits [1:0] ignored.
- bus_wr  input  1  1 = write, 0 = read; valid while bus_req is high.
- bus_wr_mask  input  4  byte-lane enables; bit i selects wdata[8i+7:8i]; used only when bus_wr = 1.
- bus_wdata  input  32  write data, already lane-aligned by the initiator.
- bus_rdata  output  32  read data; valid only in the ack cycle.
- bus_ack  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst low, asynchronous):
  - state goes to IDLE; bus_ack = 0, bus_rdata = 32'h0, wait counter = 0.
  - Memory array is not cleared; its power-up contents are unspecified.
- State machine:
  - IDLE: on a rising edge with bus_req = 1, latch addr, wr, mask and wdata. Go to WAIT if WAIT_CYCLES > 0, else go to ACK.
  - WAIT: counter is loaded with WAIT_CYCLES at capture and decrements each cycle. Go to ACK on the edge where the counter reaches 1.
  - ACK: bus_ack = 1 for exactly one cycle, then unconditionally return to IDLE.
- Memory access:
  - Performed on the edge that enters ACK.
  - Read: bus_rdata is registered from the array on that edge.
  - Write: lanes with mask = 1 are updated and lanes with mask = 0 keep their value; bus_rdata is driven to 32'h0 for writes.
- Latency: bus_ack is high WAIT_CYCLES+1 cycles after the capture edge. With WAIT_CYCLES = 0, a request first seen high in cycle N is acked in cycle N+1.
- bus_ack and bus_rdata are registered outputs and change together. The initiator samples bus_rdata in the ack cycle.
- bus_req is ignored during WAIT and ACK. The cycle after ACK is always IDLE, giving a minimum 1-cycle turnaround; a req still high in that IDLE cycle is taken as a new request.
- Protocol violation: if bus_req drops before ack, the latched transaction still completes and ack still pulses.
- Address decode:
  - in range iff ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS, computed with 33-bit arithmetic so the comparison cannot wrap.
  - word index = (addr - ADDR_BASE) >> 2, using the low log2(DEPTH_WORDS) bits.
- Out-of-range access: still acked with normal latency. Read returns 32'h0; write is discarded and no array word changes.
- Write with mask 4'b0000 is acked and changes no memory.
- Reset asserted mid-WAIT or mid-ACK aborts the transaction: no ack and no write, even if the write edge coincides with reset.

Optional Feature:
- Macro: WEAKCORE_MEM_ERR_EN.
- Defined:
  - Adds output bus_err (1 bit, sticky) and output err_addr (32 bits).
  - The first out-of-range access sets bus_err = 1 and captures its full bus_addr in err_addr, on the edge entering ACK.
  - Later errors do not overwrite err_addr.
  - Both outputs clear only on reset, to 0.
- Undefined: neither port exists; out-of-range handling is otherwise identical.

Test Plan:
- WAIT_CYCLES = 0: write addr 0x10, mask 4'b1111, wdata 0xDEADBEEF -> ack in cycle N+1. Then read 0x10 -> ack in cycle M+1 with bus_rdata = 0xDEADBEEF.
- Byte lanes: after the above, write 0x10, mask 4'b0100, wdata 0x00AB0000 -> read 0x10 returns 0xDEABBEEF. Then write mask 4'b0011, wdata 0x00001234 -> read returns 0xDEAB1234.
- WAIT_CYCLES = 3: read 0x13 (low bits ignored) -> bus_ack high exactly in cycle N+4, for one cycle, with data of word 0x10. bus_ack stays 0 in cycles N+1..N+3.
- Out of range, DEPTH_WORDS = 16, ADDR_BASE = 0x1000:
  - write 0x1040, data 0xFFFFFFFF -> acked; all 16 words unchanged.
  - read 0x0FFC -> acked, bus_rdata = 0.
  - with WEAKCORE_MEM_ERR_EN defined: bus_err = 1, err_addr = 0x1040.
- Reset mid-transaction, WAIT_CYCLES = 3: start a write of 0x55AA55AA to 0x20, drop rst for one cycle during WAIT -> no ack, bus_rdata = 0. A subsequent read of 0x20 returns the prior contents.
- Back-to-back: hold bus_req high continuously across two reads of 0x10 and 0x14 -> two separate one-cycle acks, separated by one idle cycle, each carrying the correct word.
